// File: rtl/tt_pkg.sv
// ============================================================================
// Module      : tt_pkg
// Description : Shared constants for the truth_table_lut block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam int TT_HIT_W = 16;

    // f = (x3 & ~x2) | (~x3 & ~x1), x3 is the MSB of the row index
    localparam logic [7:0] TT_INIT_3X1 = 8'h35;

endpackage

`default_nettype wire

// File: rtl/tt_out_reg.sv
// ============================================================================
// Module      : tt_out_reg
// Description : One-deep valid/ready output register shared by lookup and sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_out_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         can_load_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign can_load_o = ~valid_q | ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    // Data only moves when a load is requested, so it stays stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (can_load_o) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/truth_table_lut.sv
// ============================================================================
// Module      : truth_table_lut
// Description : Programmable N_IN x N_OUT truth table with registered valid/ready
//               output and a sweep mode. Optional hit counter: TT_HIT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_lut
    import tt_pkg::*;
#(
    parameter int                         N_IN  = 3,
    parameter int                         N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] INIT  = {N_OUT{TT_INIT_3X1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [N_IN-1:0]     cfg_addr,
    input  logic [N_OUT-1:0]    cfg_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN-1:0]     in_x,
    input  logic                sweep_start,
    output logic                sweep_busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_OUT-1:0]    out_f,
    output logic [N_IN-1:0]     out_idx,
    output logic                out_last,
    output logic [TT_HIT_W-1:0] hit_cnt,
    input  logic                hit_clr
);

    localparam int              W          = N_OUT + N_IN + 1;
    localparam logic [N_IN-1:0] c_last_row = N_IN'((2**N_IN) - 1);

    logic [(2**N_IN)*N_OUT-1:0] tbl_q;
    logic [0:0]                 state_q, state_d;
    logic [N_IN-1:0]            cnt_q, cnt_d;

    logic            w_can_load;
    logic            w_load;
    logic [N_IN-1:0] w_row;
    logic            w_last;
    logic [W-1:0]    w_data;
    logic [W-1:0]    w_out_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_load  = 1'b0;
        w_row   = in_x;
        w_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // sweep_start wins; in_ready is masked so the input is not lost
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (in_valid && w_can_load) begin
                    w_load = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (w_can_load) begin
                    w_load = 1'b1;
                    w_row  = cnt_q;
                    w_last = (cnt_q == c_last_row);
                    if (w_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + N_IN'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE) && w_can_load && !sweep_start;
    assign sweep_busy = (state_q == ST_SWEEP);
    assign w_data     = {tbl_q[int'(w_row)*N_OUT +: N_OUT], w_row, w_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reads see tbl_q, so a same-cycle write to the looked-up row returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= INIT;
        end else if (cfg_we) begin
            tbl_q[int'(cfg_addr)*N_OUT +: N_OUT] <= cfg_data;
        end
    end

    tt_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .data_i     (w_data),
        .can_load_o (w_can_load),
        .valid_o    (out_valid),
        .ready_i    (out_ready),
        .data_o     (w_out_data)
    );

    assign {out_f, out_idx, out_last} = w_out_data;

`ifdef TT_HIT_COUNT_EN
    logic [TT_HIT_W-1:0] hit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else if (hit_clr) begin
            hit_cnt_q <= '0;
        end else if (out_valid && out_ready && out_f[0] && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + TT_HIT_W'(1);
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    logic w_unused_hit_clr;

    assign w_unused_hit_clr = hit_clr;
    assign hit_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_lut.sv
// ============================================================================
// Module      : tb_truth_table_lut
// Description : Scoreboard bench for truth_table_lut (default 3x1 table).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_lut;

    typedef struct packed {
        logic       f;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [0:0]  cfg_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_x = '0;
    logic        sweep_start = 1'b0;
    logic        sweep_busy;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  out_f;
    logic [2:0]  out_idx;
    logic        out_last;
    logic [15:0] hit_cnt;
    logic        hit_clr = 1'b0;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    truth_table_lut dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_f       (out_f),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .hit_cnt     (hit_cnt),
        .hit_clr     (hit_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got f=%0h idx=%0d last=%0b expected nothing",
                         out_f, out_idx, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_f !== e.f || out_idx !== e.idx || out_last !== e.last) begin
                    n_err++;
                    $display("FAIL sb_result: got f=%0h idx=%0d last=%0b expected f=%0h idx=%0d last=%0b",
                             out_f, out_idx, out_last, e.f, e.idx, e.last);
                end
            end
        end
    end

    task automatic send(input logic [2:0] x, input logic f, output int waits);
        in_valid = 1'b1;
        in_x     = x;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{f: f, idx: x, last: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl;
        int         w;
        int         busy;
        int         spin;

        // Reset defaults
        #12;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_f",      32'(out_f),      32'd0);
        chk("rst_out_idx",    32'(out_idx),    32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_hit_cnt",    32'(hit_cnt),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Default table lookups, full throughput
        tbl = 8'h35;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), tbl[i], w);
            chk("thru_nowait", 32'(w), 32'd0);
        end
        cycles(2);

        // Backpressure hold
        out_ready = 1'b0;
        send(3'd5, 1'b1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_f",        32'(out_f),     32'd1);
            chk("bp_idx",      32'(out_idx),   32'd5);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd2, 1'b1, w);
        chk("bp_resume_nowait", 32'(w), 32'd0);

        // Same-cycle write and lookup returns old row
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 1'b1;
        send(3'd1, 1'b0, w);
        cfg_we = 1'b0;
        send(3'd1, 1'b1, w);
        cfg_we = 1'b1; cfg_data = 1'b0;
        cycles(1);
        cfg_we = 1'b0;
        send(3'd1, 1'b0, w);
        cycles(2);
        chk("sb_drain1", 32'(sb.size()), 32'd0);

        // Sweep with a competing input
        hit_clr = 1'b1;
        cycles(1);
        hit_clr = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back('{f: tbl[i], idx: 3'(i), last: (i == 7)});
        sweep_start = 1'b1;
        in_valid = 1'b1;
        in_x = 3'd6;
        @(negedge clk);
        chk("sweep_start_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        sweep_start = 1'b0;
        busy = 0;
        spin = 0;
        while (spin < 30) begin
            @(negedge clk);
            spin++;
            if (sweep_busy) begin
                busy++;
                if (in_ready) chk("sweep_in_ready", 32'(in_ready), 32'd0);
            end else if (busy > 0) begin
                break;
            end
        end
        chk("sweep_busy_cycles", 32'(busy), 32'd8);
        chk("post_sweep_in_ready", 32'(in_ready), 32'd1);
        sb.push_back('{f: 1'b0, idx: 3'd6, last: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles(2);
        chk("sb_drain2", 32'(sb.size()), 32'd0);
`ifdef TT_HIT_COUNT_EN
        chk("hit_sweep", 32'(hit_cnt), 32'd4);
`else
        chk("hit_tied", 32'(hit_cnt), 32'd0);
`endif
        send(3'd0, 1'b1, w);
        hit_clr = 1'b1;
        cycles(1);
        hit_clr = 1'b0;
        chk("hit_clr_prio", 32'(hit_cnt), 32'd0);

        // Reset mid-sweep restores table
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 1'b1;
        cycles(1);
        cfg_we = 1'b0;
        tbl = 8'h37;
        for (int i = 0; i < 8; i++) sb.push_back('{f: tbl[i], idx: 3'(i), last: (i == 7)});
        sweep_start = 1'b1;
        cycles(1);
        sweep_start = 1'b0;
        spin = 0;
        @(negedge clk);
        while (!(out_valid && out_idx == 3'd3) && spin < 20) begin
            spin++;
            @(negedge clk);
        end
        chk("reach_row3", 32'(out_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid",  32'(out_valid),  32'd0);
        chk("arst_out_f",      32'(out_f),      32'd0);
        chk("arst_out_idx",    32'(out_idx),    32'd0);
        chk("arst_out_last",   32'(out_last),   32'd0);
        chk("arst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("arst_hit_cnt",    32'(hit_cnt),    32'd0);
        cycles(1);
        rst_n = 1'b1;
        cycles(1);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        send(3'd1, 1'b0, w);
        cycles(2);
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
